// File: rtl/cnt_seq.sv
// cnt_seq: sequencer that steers an external up/down counter through
// up-once, down-once or bounce (up/down round trips) sequences.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   nrst     - asynchronous active-low reset
//   start    - begin a sequence (sampled in IDLE only)
//   mode     - 00 up-once, 01 down-once, 10 bounce, 11 reserved (rejected)
//   limit    - up-count target, latched at start
//   passes   - bounce round trips, latched at start (0 means 1)
//   abort    - terminate the running sequence at the next edge
//   cnt_q    - present value of the external counter
//   cnt_en   - counter enable (combinational)
//   cnt_down - counter direction, 1 = down
//   busy     - sequencer not in IDLE
//   done     - one-cycle completion pulse
//   err      - one-cycle pulse after a rejected (reserved-mode) start
module cnt_seq #(
    parameter int W  = 3,
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  limit,
    input  logic [PW-1:0] passes,
    input  logic          abort,
    input  logic [W-1:0]  cnt_q,
    output logic          cnt_en,
    output logic          cnt_down,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0]    MODE_DOWN = 2'b01;
    localparam logic [1:0]    MODE_BNC  = 2'b10;
    localparam logic [1:0]    MODE_RSV  = 2'b11;
    localparam logic [PW-1:0] PASS_ONE  = PW'(1'b1);

    state_t        state_r, state_s;
    logic [W-1:0]  lim_r, lim_s;
    logic [1:0]    mode_r, mode_s;
    logic [PW-1:0] pass_r, pass_s;
    logic          err_r, err_s;
    logic          cnt_en_s;
    logic          at_lim_s;
    logic          at_zero_s;

    assign at_lim_s  = (cnt_q == lim_r);
    assign at_zero_s = (cnt_q == {W{1'b0}});

    // Next-state, parameter latching and counter-enable decode
    always_comb begin
        state_s  = state_r;
        lim_s    = lim_r;
        mode_s   = mode_r;
        pass_s   = pass_r;
        err_s    = 1'b0;
        cnt_en_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                // abort together with start suppresses both acceptance and err
                if (start && !abort) begin
                    if (mode == MODE_RSV) begin
                        err_s = 1'b1;
                    end else begin
                        lim_s  = limit;
                        mode_s = mode;
                        pass_s = (passes == {PW{1'b0}}) ? PASS_ONE : passes;
                        state_s = (mode == MODE_DOWN) ? S_DOWN : S_UP;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_UP: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (at_lim_s) begin
                    // the turnaround cycle itself never enables the counter
                    state_s = (mode_r == MODE_BNC) ? S_DOWN : S_DONE;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            S_DOWN: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (at_zero_s) begin
                    if (mode_r == MODE_BNC) begin
                        if (pass_r == PASS_ONE) begin
                            state_s = S_DONE;
                        end else begin
                            pass_s  = pass_r - PASS_ONE;
                            state_s = S_UP;
                        end
                    end else begin
                        state_s = S_DONE;
                    end
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, latched parameters and error pulse registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= S_IDLE;
            lim_r   <= {W{1'b0}};
            mode_r  <= 2'b00;
            pass_r  <= {PW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            lim_r   <= lim_s;
            mode_r  <= mode_s;
            pass_r  <= pass_s;
            err_r   <= err_s;
        end
    end

    assign cnt_en   = cnt_en_s;
    assign cnt_down = (state_r == S_DOWN);
    assign busy     = (state_r != S_IDLE);
    // an abort during the DONE cycle cancels the completion pulse
    assign done     = (state_r == S_DONE) && !abort;
    assign err      = err_r;

endmodule

// File: tb/tb_cnt_seq.sv
module tb_cnt_seq;

    logic       clk;
    logic       nrst;
    logic       start;
    logic [1:0] mode;
    logic [2:0] limit;
    logic [1:0] passes;
    logic       abort;
    logic [2:0] cnt_q;
    logic       cnt_en, cnt_down, busy, done, err;

    // environment counter with a test preload port
    logic       ld;
    logic [2:0] ld_val;

    int total = 0;
    int bad   = 0;

    cnt_seq #(.W(3), .PW(2)) dut (
        .clk(clk), .nrst(nrst), .start(start), .mode(mode), .limit(limit),
        .passes(passes), .abort(abort), .cnt_q(cnt_q), .cnt_en(cnt_en),
        .cnt_down(cnt_down), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external up/down counter sharing the reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)       cnt_q <= 3'd0;
        else if (ld)     cnt_q <= ld_val;
        else if (cnt_en) cnt_q <= cnt_down ? cnt_q - 3'd1 : cnt_q + 3'd1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (sequence plan as a queue) -------------
    typedef struct packed { logic en; logic down; logic dn; } step_t;
    step_t      plan_q[$];
    logic       err_pend;
    logic [2:0] mq;

    task automatic push(input logic en, input logic down, input logic dn);
        step_t s;
        s.en = en; s.down = down; s.dn = dn;
        plan_q.push_back(s);
    endtask

    // Expected per-cycle behaviour from the accepted start onwards
    task automatic build_plan(input int q0, input int lim, input int md, input int ps);
        int p, cur, n;
        p   = (ps == 0) ? 1 : ps;
        cur = q0;
        if (md == 1) begin
            for (int i = 0; i < q0; i++) push(1'b1, 1'b1, 1'b0);
            push(1'b0, 1'b1, 1'b0);
        end else begin
            for (int t = 0; t < ((md == 2) ? p : 1); t++) begin
                n = (lim - cur + 8) % 8;
                for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b0);
                push(1'b0, 1'b0, 1'b0);
                if (md == 2) begin
                    for (int i = 0; i < lim; i++) push(1'b1, 1'b1, 1'b0);
                    push(1'b0, 1'b1, 1'b0);
                end
                cur = 0;
            end
        end
        push(1'b0, 1'b0, 1'b1);
    endtask

    task automatic model_clear();
        plan_q.delete();
        err_pend = 1'b0;
        mq = 3'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0; start = 1'b0; abort = 1'b0; ld = 1'b0;
        #2;
        nrst = 1'b1;
        model_clear();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int mode; int lim; int ps; int q0; int en_n; int done_cyc; int q_end;
    } vec_t;
    vec_t vecs[9];

    task automatic run_vec(input int idx, input vec_t v);
        int en_n, first_done, done_n, busy_after;
        en_n = 0; first_done = 0; done_n = 0; busy_after = 1;
        do_reset();
        @(negedge clk);
        ld = 1'b1; ld_val = 3'(v.q0);
        @(negedge clk);
        ld = 1'b0;
        start = 1'b1; mode = 2'(v.mode); limit = 3'(v.lim); passes = 2'(v.ps);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            #1;
            if (cnt_en) en_n++;
            if (done) begin
                done_n++;
                if (first_done == 0) first_done = k;
            end
            if (first_done != 0 && k == first_done + 1) busy_after = busy;
            if (first_done != 0 && k >= first_done + 2) break;
            @(negedge clk);
        end
        check($sformatf("v%0d_en_cycles", idx), en_n, v.en_n);
        check($sformatf("v%0d_done_cycle", idx), first_done, v.done_cyc);
        check($sformatf("v%0d_done_count", idx), done_n, 1);
        check($sformatf("v%0d_q_end", idx), int'(cnt_q), v.q_end);
        check($sformatf("v%0d_busy_after", idx), busy_after, 0);
    endtask

    int       done_seen;
    int       en_seen;
    int       down_seen;
    logic     e_busy, e_en, e_down, e_done, e_err, idle;
    step_t    ent;

    initial begin
        nrst = 1'b0; start = 1'b0; mode = 2'b00; limit = 3'd0; passes = 2'd0;
        abort = 1'b0; ld = 1'b0; ld_val = 3'd0;
        model_clear();

        vecs[0] = '{0, 5, 0, 0,  5,  7, 5};
        vecs[1] = '{1, 0, 0, 5,  5,  7, 0};
        vecs[2] = '{2, 3, 2, 0, 12, 17, 0};
        vecs[3] = '{0, 1, 0, 6,  3,  5, 1};
        vecs[4] = '{0, 4, 0, 4,  0,  2, 4};
        vecs[5] = '{1, 3, 0, 0,  0,  2, 0};
        vecs[6] = '{2, 2, 0, 0,  4,  7, 0};
        vecs[7] = '{2, 7, 3, 5, 37, 44, 0};
        vecs[8] = '{0, 0, 0, 3,  5,  7, 0};

        // reset state
        #1;
        check("reset_outputs", int'({cnt_en, cnt_down, busy, done, err}), 0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // abort in UP at cnt_q=2
        do_reset();
        @(negedge clk);
        start = 1'b1; mode = 2'b00; limit = 3'd6;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_q_at_2", int'(cnt_q), 2);
        check("abort_en_comb", int'(cnt_en), 0);
        check("abort_busy_same", int'(busy), 1);
        @(negedge clk); abort = 1'b0;
        #1;
        check("abort_idle_next", int'(busy), 0);
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) done_seen++;
            @(negedge clk); #1;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_q_held", int'(cnt_q), 2);

        // reserved mode start -> err pulse
        do_reset();
        @(negedge clk);
        start = 1'b1; mode = 2'b11; limit = 3'd4;
        @(negedge clk); start = 1'b0;
        #1;
        check("rsv_err_pulse", int'(err), 1);
        check("rsv_busy", int'(busy), 0);
        @(negedge clk); #1;
        check("rsv_err_once", int'(err), 0);

        // start together with abort in IDLE is ignored
        @(negedge clk);
        start = 1'b1; mode = 2'b11; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        #1;
        check("start_abort_err", int'(err), 0);
        check("start_abort_busy", int'(busy), 0);

        // start while busy is ignored, latched parameters unchanged
        do_reset();
        @(negedge clk);
        start = 1'b1; mode = 2'b00; limit = 3'd3; passes = 2'd0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 2'b01; limit = 3'd7; passes = 2'd3;
        done_seen = 0; down_seen = 0;
        for (int k = 2; k <= 8; k++) begin
            #1;
            if (done && done_seen == 0) done_seen = k;
            if (cnt_down) down_seen++;
            if (k == 4) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_start_done_cycle", done_seen, 5);
        check("busy_start_no_down", down_seen, 0);
        check("busy_start_q_end", int'(cnt_q), 3);

        // nrst pulse mid-run clears outputs asynchronously; first edge accepts start
        do_reset();
        @(negedge clk);
        start = 1'b1; mode = 2'b00; limit = 3'd7;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2; nrst = 1'b0;
        #1;
        check("async_rst_outputs", int'({cnt_en, cnt_down, busy, done, err}), 0);
        check("async_rst_counter", int'(cnt_q), 0);
        start = 1'b1; mode = 2'b00; limit = 3'd2;
        #1; nrst = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        check("rst_first_edge_busy", int'(busy), 1);
        check("rst_first_edge_en", int'(cnt_en), 1);

        // randomized run against the plan model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 3) == 0);
            mode   = 2'($urandom_range(0, 3));
            limit  = 3'($urandom_range(0, 7));
            passes = 2'($urandom_range(0, 3));
            abort  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) begin
                nrst = 1'b0;
                #1;
                model_clear();
                nrst = 1'b1;
            end
            #1;
            idle = (plan_q.size() == 0);
            if (idle) begin
                e_busy = 1'b0; e_en = 1'b0; e_down = 1'b0; e_done = 1'b0;
            end else begin
                ent    = plan_q[0];
                e_busy = 1'b1;
                e_en   = ent.en && !abort;
                e_down = ent.down;
                e_done = ent.dn && !abort;
            end
            e_err = err_pend;
            check("rnd_busy", int'(busy), int'(e_busy));
            check("rnd_cnt_en", int'(cnt_en), int'(e_en));
            check("rnd_cnt_down", int'(cnt_down), int'(e_down));
            check("rnd_done", int'(done), int'(e_done));
            check("rnd_err", int'(err), int'(e_err));
            check("rnd_cnt_q", int'(cnt_q), int'(mq));
            err_pend = idle && start && !abort && (mode == 2'b11);
            if (e_en) mq = e_down ? mq - 3'd1 : mq + 3'd1;
            if (idle) begin
                if (start && !abort && mode != 2'b11)
                    build_plan(int'(mq), int'(limit), int'(mode), int'(passes));
            end else if (abort) begin
                plan_q.delete();
            end else begin
                void'(plan_q.pop_front());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnt_seq.md
CNT_SEQ -- requirements
Module: cnt_seq

Interface
REQ-001 The module SHALL have parameter W, default 3, giving the width of the controlled counter.
REQ-002 The module SHALL have parameter PW, default 2, giving the width of the bounce-pass count.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port start, input, 1 bit: request to begin a sequence; sampled in IDLE only.
REQ-006 The module SHALL have port mode, input, 2 bits: 00 up-once, 01 down-once, 10 bounce, 11 reserved.
REQ-007 The module SHALL have port limit, input, W bits: up-count target.
REQ-008 The module SHALL have port passes, input, PW bits: number of bounce round trips; 0 means 1.
REQ-009 The module SHALL have port abort, input, 1 bit: terminate the sequence immediately.
REQ-010 The module SHALL have port cnt_q, input, W bits: present value of the external up/down counter.
REQ-011 The module SHALL have port cnt_en, output, 1 bit: count enable to the counter.
REQ-012 The module SHALL have port cnt_down, output, 1 bit: direction to the counter (1 = down).
REQ-013 The module SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-014 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 The module SHALL have port err, output, 1 bit: one-cycle pulse when start is rejected.

Function
REQ-016 The FSM SHALL have states IDLE, UP, DOWN and DONE.
REQ-017 In IDLE, start=1 with mode≠11 and abort=0 SHALL latch mode, limit and passes (0 becomes 1) at the clock edge.
REQ-018 On that edge the state SHALL go to DOWN for mode 01, otherwise to UP.
REQ-019 In IDLE, start=1 with mode=11 SHALL set err=1 for the next cycle only, with the state remaining IDLE.
REQ-020 start SHALL be ignored in all states other than IDLE; the latched parameters SHALL NOT change mid-sequence.
REQ-021 cnt_en SHALL be combinational: (UP and cnt_q≠lim_r) or (DOWN and cnt_q≠0), forced to 0 when abort=1.
REQ-022 cnt_down SHALL be 1 exactly when the state is DOWN.
REQ-023 UP with cnt_q≠lim_r SHALL hold the state; counting SHALL wrap through 2^W-1 to 0 when cnt_q>lim_r.
REQ-024 UP with cnt_q==lim_r SHALL go to DONE in up-once mode and to DOWN in bounce mode.
REQ-025 DOWN with cnt_q==0 SHALL go to DONE in down-once mode.
REQ-026 In bounce mode, DOWN with cnt_q==0 SHALL decrement the remaining passes; on reaching 0 it SHALL go to DONE, otherwise to UP.
REQ-027 DONE SHALL last one cycle with done=1, then go to IDLE; back-to-back start is accepted in the following IDLE cycle.
REQ-028 Latency: with start sampled at edge E, cnt_en SHALL first be high in the cycle after E.
REQ-029 For up-once from q0, done SHALL be high in cycle (lim_r−q0 mod 2^W)+2 after E.
REQ-030 If the target already equals cnt_q at entry, there SHALL be zero enabled cycles, and done SHALL be high at cycle 2 after E.
REQ-031 abort=1 in UP, DOWN or DONE SHALL force state IDLE at the next edge, with cnt_en=0 combinationally and no done pulse.
REQ-032 abort in IDLE SHALL have no effect; abort together with start SHALL mean start is ignored (no err).
REQ-033 The counter value SHALL NOT be modified by the block apart than through cnt_en and cnt_down.

Reset
REQ-034 nrst=0 SHALL immediately force IDLE, clear lim_r, mode and pass registers, and drive cnt_en=0, cnt_down=0, busy=0, done=0, err=0.
REQ-035 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse.
REQ-036 After nrst rises, the first edge SHALL be able to accept start.
REQ-037 The counter SHALL share nrst and is then at 0.

Verification
REQ-038 Reset, W=3, mode 00, limit 5, start 1 cycle -> cnt_en high 5 cycles, cnt_q 0..5, done in cycle 7 after start edge, busy 0 after.
REQ-039 From cnt_q=5, mode 01 -> cnt_down=1, 5 enabled cycles to 0, single done pulse.
REQ-040 Bounce with limit 3, passes 2, from 0 -> sequence 0..3..0..3..0, exactly one done, cnt_en never high at turnarounds.
REQ-041 Abort in UP at cnt_q=2 -> cnt_en 0 same cycle, IDLE next cycle, no done, cnt_q held at 2.
REQ-042 Mode 11 start -> err pulse 1 cycle, busy stays 0; start while busy -> ignored, parameters unchanged.
REQ-043 Up-once from cnt_q=6, limit 1 -> wrap 7,0,1 (3 enabled cycles); nrst pulse mid-run -> all outputs 0 asynchronously.
